// File: rtl/clk_div_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_div_prog : programmable 50%-duty clock divider, odd and even N       |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module clk_div_prog #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_act,
  output logic             div_busy,
  output logic             div_err,
  output logic             tick
);

  localparam logic [WIDTH-1:0] c_def_div = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] c_min_div = WIDTH'(2);
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

  logic [WIDTH-1:0] count_q,   count_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] pend_q,    pend_d;
  logic             pos_q,     pos_d;
  logic             neg_q,     neg_d;
  logic             busy_q,    busy_d;
  logic             err_q,     err_d;
  logic             run_q,     run_d;

  logic w_tick;
  logic w_load_ok;
  logic w_load_bad;

  assign w_tick     = en && (count_q == div_act_q - c_one);
  assign w_load_ok  = div_load && (div_in >= c_min_div);
  assign w_load_bad = div_load && (div_in <  c_min_div);

  always_comb begin
    count_d   = count_q;
    div_act_d = div_act_q;
    pend_d    = pend_q;
    pos_d     = pos_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    run_d     = en;
    if (rst) begin
      count_d   = '0;
      div_act_d = c_def_div;
      pend_d    = '0;
      pos_d     = 1'b0;
      busy_d    = 1'b0;
      run_d     = 1'b0;
    end else begin
      err_d = w_load_bad;
      // Divisor changes land only on a period boundary (or while stopped).
      if (!en) begin
        if (w_load_ok) begin
          div_act_d = div_in;
          busy_d    = 1'b0;
        end else if (busy_q) begin
          div_act_d = pend_q;
          busy_d    = 1'b0;
        end
      end else if (w_load_ok) begin
        if (w_tick) begin
          div_act_d = div_in;
          busy_d    = 1'b0;
        end else begin
          pend_d = div_in;
          busy_d = 1'b1;
        end
      end else if (w_tick && busy_q) begin
        div_act_d = pend_q;
        busy_d    = 1'b0;
      end

      // The wrap decision uses the old divisor; the high phase uses the new one.
      if (!en || !run_q || w_tick) begin
        count_d = '0;
      end else begin
        count_d = count_q + c_one;
      end
      pos_d = en && (count_d < (div_act_d >> 1));
    end
  end

  always_comb begin
    neg_d = rst ? 1'b0 : pos_q;
  end

  always_ff @(posedge clk) begin
    count_q   <= count_d;
    div_act_q <= div_act_d;
    pend_q    <= pend_d;
    pos_q     <= pos_d;
    busy_q    <= busy_d;
    err_q     <= err_d;
    run_q     <= run_d;
  end

  // Half-cycle delayed copy stretches the high phase by half a clk for odd N.
  always_ff @(negedge clk) begin
    neg_q <= neg_d;
  end

  assign clk_out  = pos_q | (neg_q & div_act_q[0]);
  assign count    = count_q;
  assign div_act  = div_act_q;
  assign div_busy = busy_q;
  assign div_err  = err_q;
  assign tick     = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clk_div_prog : scoreboard bench for clk_div_prog                      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_clk_div_prog;

  localparam int WIDTH = 8;
  localparam int HALF  = 5;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_act;
  logic             div_busy;
  logic             div_err;
  logic             tick;

  clk_div_prog #(.WIDTH(WIDTH), .DEF_DIV(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .clk_out  (clk_out),
    .count    (count),
    .div_act  (div_act),
    .div_busy (div_busy),
    .div_err  (div_err),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  // Expected clk_out periods, measured in half clk periods (clk period = 2).
  typedef struct packed {
    int high;
    int low;
  } per_t;

  per_t   exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     epoch   = 0;
  int     rise_epoch = -1;
  int     ticks   = 0;
  bit     have_rise = 1'b0;
  bit     have_fall = 1'b0;
  longint t_rise  = 0;
  longint t_fall  = 0;

  function automatic void check(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic push(int h, int l, int n);
    per_t e;
    e.high = h;
    e.low  = l;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cyc();
      n++;
    end
    check({name, "_periods_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: tick occurrences sampled mid-cycle.
  always @(negedge clk) begin
    if (tick === 1'b1) ticks++;
  end

  // Monitor: each completed rise-to-rise period is scored against the queue.
  always @(posedge clk_out) begin
    per_t e;
    if (have_rise && have_fall && rise_epoch == epoch && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("period_high", (t_fall - t_rise) / HALF, e.high);
      check("period_low",  ($time - t_fall) / HALF,  e.low);
      check("ticks_per_period", ticks, 1);
    end
    have_rise  = 1'b1;
    have_fall  = 1'b0;
    rise_epoch = epoch;
    t_rise     = $time;
    ticks      = 0;
  end

  always @(negedge clk_out) begin
    if (have_rise) begin
      t_fall    = $time;
      have_fall = 1'b1;
    end
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
    repeat (3) cyc();
    check("rst_clk_out", clk_out, 0);
    check("rst_count", count, 0);
    check("rst_div_act", div_act, 5);
    check("rst_busy", div_busy, 0);
    check("rst_err", div_err, 0);
    check("rst_tick", tick, 0);

    // Defaults: N=5 -> high 5 / low 5, one tick each period.
    push(5, 5, 3);
    rst = 1'b0; en = 1'b1;
    cyc();
    check("start_count", count, 0);
    check("start_clk_out", clk_out, 1);
    cyc();
    check("start_count_adv", count, 1);
    wait_drain("defaults");

    // Rejected load of 1.
    push(5, 5, 2);
    div_in = 8'd1; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check("err_pulse", div_err, 1);
    check("err_div_act", div_act, 5);
    check("err_busy", div_busy, 0);
    cyc();
    check("err_clear", div_err, 0);
    wait_drain("err");

    // Load 4, registered on the edge where count becomes 2.
    n = 0;
    while (count != 1 && n < 20) begin cyc(); n++; end
    check("align_count1", count, 1);
    push(5, 5, 1);
    push(4, 4, 2);
    div_in = 8'd4; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check("load4_count", count, 2);
    n = 0;
    while (div_busy && n < 20) begin n++; cyc(); end
    check("load4_busy_cycles", n, 3);
    check("load4_div_act", div_act, 4);
    check("load4_count_wrap", count, 0);
    wait_drain("load4");

    // Two loads in one period: 3 then 9; only 9 is applied at the wrap.
    push(4, 4, 1);
    push(9, 9, 2);
    div_in = 8'd3; div_load = 1'b1;
    cyc();
    div_in = 8'd9;
    cyc();
    div_load = 1'b0;
    check("two_busy", div_busy, 1);
    check("two_div_act_old", div_act, 4);
    n = 0;
    while (div_busy && n < 20) begin cyc(); n++; end
    check("two_div_act_new", div_act, 9);
    check("two_count_wrap", count, 0);
    wait_drain("two_loads");

    // Load 7 coinciding with tick: applied at that wrap, never busy.
    n = 0;
    while (tick != 1'b1 && n < 20) begin cyc(); n++; end
    check("align_tick", tick, 1);
    push(9, 9, 1);
    push(7, 7, 1);
    div_in = 8'd7; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check("tickload_div_act", div_act, 7);
    check("tickload_busy", div_busy, 0);
    check("tickload_count", count, 0);
    wait_drain("tick_load");

    // Drop en at count=1 with N=7, then re-enable.
    cyc();
    check("drop_count1", count, 1);
    epoch++;
    en = 1'b0;
    cyc();
    check("drop_count0", count, 0);
    #4;
    check("drop_clk_out", clk_out, 0);
    cyc();
    cyc();
    check("idle_clk_out", clk_out, 0);
    check("idle_count", count, 0);
    check("idle_tick", tick, 0);
    push(7, 7, 2);
    en = 1'b1;
    cyc();
    check("reen_count", count, 0);
    check("reen_clk_out", clk_out, 1);
    wait_drain("reenable");

    // Load 6 while disabled: applied on the next edge, no busy.
    epoch++;
    en = 1'b0;
    cyc();
    div_in = 8'd6; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check("dis_load_div_act", div_act, 6);
    check("dis_load_busy", div_busy, 0);
    push(6, 6, 1);
    en = 1'b1;
    cyc();
    wait_drain("n6");

    // Reset mid-period with a load pending.
    cyc();
    cyc();
    div_in = 8'd8; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check("pend_busy", div_busy, 1);
    epoch++;
    rst = 1'b1;
    cyc();
    check("mid_rst_count", count, 0);
    check("mid_rst_div_act", div_act, 5);
    check("mid_rst_busy", div_busy, 0);
    check("mid_rst_err", div_err, 0);
    check("mid_rst_tick", tick, 0);
    #4;
    check("mid_rst_clk_out", clk_out, 0);
    div_in = 8'd9; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check("rst_load_div_act", div_act, 5);
    check("rst_load_busy", div_busy, 0);
    push(5, 5, 2);
    rst = 1'b0;
    cyc();
    check("post_rst_count", count, 0);
    check("post_rst_clk_out", clk_out, 1);
    wait_drain("post_rst");
    check("post_rst_div_act", div_act, 5);
    check("post_rst_busy", div_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
